// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads a synchronous instruction memory with one
// cycle of latency and presents one registered instruction per cycle with
// valid/stall flow control. Redirects on pc_overwrite and stops on HALT.
module instruction_fetch #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               pc_overwrite,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic               halt,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               halted
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;   // next address to issue
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;       // address issued last cycle
    logic               req_valid_q, req_valid_d; // data for req_pc counts
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
    logic               halted_q, halted_d;

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc_out      = pc_out_q;
    assign halted      = halted_q;

    // Next-state, next-PC and imem address selection.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        req_valid_d = req_valid_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        pc_out_d    = pc_out_q;
        halted_d    = halted_q;
        imem_addr   = req_pc_q;
        case (state_q)
            ST_BOOT: begin
                imem_addr   = {ADDR_W{1'b0}};
                req_pc_d    = {ADDR_W{1'b0}};
                req_valid_d = 1'b1;
                fetch_pc_d  = {{(ADDR_W-1){1'b0}}, 1'b1};
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                if (stall) begin
                    // Re-read the outstanding address so rdata matches req_pc
                    // when the stall releases.
                    imem_addr = req_pc_q;
                end else if (valid_q && halt) begin
                    imem_addr   = req_pc_q;
                    state_d     = ST_HALTED;
                    valid_d     = 1'b0;
                    req_valid_d = 1'b0;
                    halted_d    = 1'b1;
                end else if (valid_q && pc_overwrite) begin
                    // The sequential word arriving now is dropped: one bubble.
                    imem_addr   = jump_target;
                    req_pc_d    = jump_target;
                    req_valid_d = 1'b1;
                    fetch_pc_d  = jump_target + {{(ADDR_W-1){1'b0}}, 1'b1};
                    valid_d     = 1'b0;
                end else begin
                    imem_addr   = fetch_pc_q;
                    fetch_pc_d  = fetch_pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    req_pc_d    = fetch_pc_q;
                    req_valid_d = 1'b1;
                    instr_d     = imem_rdata;
                    pc_out_d    = req_pc_q;
                    valid_d     = req_valid_q;
                end
            end
            ST_HALTED: begin
                imem_addr = req_pc_q;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_BOOT;
            fetch_pc_q  <= {ADDR_W{1'b0}};
            req_pc_q    <= {ADDR_W{1'b0}};
            req_valid_q <= 1'b0;
            instr_q     <= {INSTR_W{1'b0}};
            valid_q     <= 1'b0;
            pc_out_q    <= {ADDR_W{1'b0}};
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            pc_out_q    <= pc_out_d;
            halted_q    <= halted_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed scenarios followed by random
// stall/redirect/halt/reset traffic, checked by a stream-level reference model
// through an expected-output queue.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic [7:0]  imem_addr;
    logic [23:0] imem_rdata;
    logic        stall;
    logic        pc_overwrite;
    logic [7:0]  jump_target;
    logic        halt;
    logic [23:0] instruction;
    logic        instr_valid;
    logic [7:0]  pc_out;
    logic        halted;

    int checks = 0;
    int errors = 0;

    instruction_fetch #(.ADDR_W(8), .INSTR_W(24)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .pc_overwrite (pc_overwrite),
        .jump_target  (jump_target),
        .halt         (halt),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .pc_out       (pc_out),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] mem_word(input logic [7:0] a);
        return 24'hA00000 | {16'h0000, a};
    endfunction

    // Synchronous instruction memory, one cycle read latency.
    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    // Expected observable state after each clock edge.
    typedef struct {
        bit         zeros;   // outputs still at reset values
        bit         valid;
        logic [7:0] pc;
        bit         hlt;
        int         phase;   // 0 boot, 1 running, 2 halted
        logic [7:0] nxt;     // next PC due to be presented
    } exp_t;

    exp_t exp_q[$];

    // Reference model: a stream of PCs consumed one per unstalled cycle.
    bit         m_zeros = 1'b1;
    bit         m_valid = 1'b0;
    bit         m_halted = 1'b0;
    int         m_phase = 0;
    logic [7:0] m_pc = 8'h00;
    logic [7:0] m_next = 8'h00;

    always @(posedge clk) begin
        exp_t e;
        if (!rst) begin
            m_zeros = 1'b1; m_valid = 1'b0; m_halted = 1'b0;
            m_phase = 0; m_pc = 8'h00; m_next = 8'h00;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_halted || stall) begin
            // nothing moves
        end else if (m_valid && halt) begin
            m_halted = 1'b1; m_valid = 1'b0; m_phase = 2;
        end else if (m_valid && pc_overwrite) begin
            m_valid = 1'b0; m_next = jump_target;
        end else begin
            m_valid = 1'b1; m_pc = m_next; m_next = m_next + 8'd1; m_zeros = 1'b0;
        end
        e.zeros = m_zeros; e.valid = m_valid; e.pc = m_pc;
        e.hlt = m_halted; e.phase = m_phase; e.nxt = m_next;
        exp_q.push_back(e);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor: compares DUT outputs with the queued expectation each cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [7:0] inc;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, e.valid});
            chk("halted", {31'd0, halted}, {31'd0, e.hlt});
            if (e.zeros) begin
                chk("pc_out_rst", {24'd0, pc_out}, 32'd0);
                chk("instruction_rst", {8'd0, instruction}, 32'd0);
            end else if (e.valid || e.hlt) begin
                chk("pc_out", {24'd0, pc_out}, {24'd0, e.pc});
                chk("instruction", {8'd0, instruction}, {8'd0, mem_word(e.pc)});
            end
            inc = e.nxt + 8'd1;
            if (e.phase == 0) begin
                chk("imem_addr_boot", {24'd0, imem_addr}, 32'd0);
            end else if (e.phase == 2) begin
                chk("imem_addr_halted", {24'd0, imem_addr}, {24'd0, e.nxt});
            end else if (stall) begin
                chk("imem_addr_stall", {24'd0, imem_addr}, {24'd0, e.nxt});
            end else if (e.valid && halt) begin
                // address while halting is irrelevant
            end else if (e.valid && pc_overwrite) begin
                chk("imem_addr_jump", {24'd0, imem_addr}, {24'd0, jump_target});
            end else begin
                chk("imem_addr_seq", {24'd0, imem_addr}, {24'd0, inc});
            end
        end
    end

    task automatic drive(input bit r, input bit s, input bit ov, input logic [7:0] t, input bit h);
        @(posedge clk);
        #1;
        rst = r; stall = s; pc_overwrite = ov; jump_target = t; halt = h;
    endtask

    // Idle until the model presents PC p (bounded).
    task automatic wait_pc(input logic [7:0] p);
        int n = 0;
        while (!(m_valid && m_pc == p) && n < 600) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            n++;
        end
        checks++;
        if (!(m_valid && m_pc == p)) begin
            errors++;
            $display("FAIL wait_pc: never reached pc %0h, model pc %0h", p, m_pc);
        end
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; pc_overwrite = 1'b0; jump_target = 8'h00; halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        // Stall while pc 3 is presented, then continue.
        wait_pc(8'h03);
        repeat (3) drive(1'b1, 1'b1, 1'b1, 8'h77, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        // Redirect at pc 5 to 0x20.
        wait_pc(8'h05);
        drive(1'b1, 1'b0, 1'b1, 8'h20, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        // Halt at 0x23, then poke inputs that must be ignored.
        wait_pc(8'h23);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++)
            drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        // One-cycle reset while halted and stalled.
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        // Jump to 0xFF and check wrap to 0x00.
        wait_pc(8'h02);
        drive(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        wait_pc(8'hFF);
        wait_pc(8'h00);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 99) >= 2,
                  $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 12,
                  8'($urandom_range(0, 255)),
                  $urandom_range(0, 99) < 2);
        end
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
